// File: rtl/unified_cache_mem_responder.sv
// Memory-side responder below the last cache level: serves miss and writeback
// requests one at a time from an internal block array after a fixed latency.
// Optional statistics counters: define UNIFIED_CACHE_MEM_RESPONDER_STATS_EN.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif

module unified_cache_mem_responder #(
  parameter int unsigned PACKET_WIDTH       = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int unsigned BLOCK_SIZE_IN_BITS = 32,
  parameter int unsigned ADDR_POS_LO        = 0,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_POS_LO        = 32,
  parameter int unsigned NUM_BLOCKS         = 16,
  parameter int unsigned BLOCK_OFFSET_BITS  = 2,
  parameter int unsigned ACCESS_LATENCY     = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [PACKET_WIDTH-1:0] miss_request_in,
  input  logic                    miss_request_valid_in,
  output logic                    miss_request_ack_out,
  input  logic [PACKET_WIDTH-1:0] writeback_request_in,
  input  logic                    writeback_request_valid_in,
  output logic                    writeback_request_ack_out,
  output logic [PACKET_WIDTH-1:0] fetched_request_out,
  output logic                    fetched_request_valid_out,
  input  logic                    fetched_request_ack_in
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]             stat_miss_served_out,
  output logic [31:0]             stat_writeback_served_out,
  output logic [31:0]             stat_stall_cycles_out
`endif
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Build-time sanity of the packet layout and parameters
  if (DATA_POS_LO + BLOCK_SIZE_IN_BITS > PACKET_WIDTH) begin : g_bad_data_field
    $error("data field does not fit in PACKET_WIDTH");
  end
  if (ADDR_POS_LO + ADDR_WIDTH > PACKET_WIDTH) begin : g_bad_addr_field
    $error("address field does not fit in PACKET_WIDTH");
  end
  if (BLOCK_OFFSET_BITS + IDX_W > ADDR_WIDTH) begin : g_bad_index
    $error("block index exceeds the address field");
  end
  if (ACCESS_LATENCY < 1) begin : g_bad_latency
    $error("ACCESS_LATENCY must be at least 1");
  end
  if (NUM_BLOCKS < 2 || (NUM_BLOCKS & (NUM_BLOCKS - 1)) != 0) begin : g_bad_depth
    $error("NUM_BLOCKS must be a power of 2, at least 2");
  end

  logic [1:0]                    state, state_next;
  logic [CNT_W-1:0]              cnt, cnt_next;
  logic [PACKET_WIDTH-1:0]       pkt, pkt_next;
  logic                          miss_ack_next, wb_ack_next;
  logic                          resp_valid_next;
  logic [PACKET_WIDTH-1:0]       resp_pkt_next;
  logic                          mem_we;
  logic                          count_done;
  logic [IDX_W-1:0]              idx;
  logic [BLOCK_SIZE_IN_BITS-1:0] mem [NUM_BLOCKS];

  assign idx        = pkt[ADDR_POS_LO + BLOCK_OFFSET_BITS +: IDX_W];
  assign count_done = (cnt == CNT_W'(ACCESS_LATENCY - 1));

  // Next-state and next-output decode
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    pkt_next        = pkt;
    miss_ack_next   = 1'b0;
    wb_ack_next     = 1'b0;
    resp_valid_next = fetched_request_valid_out;
    resp_pkt_next   = fetched_request_out;
    mem_we          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (writeback_request_valid_in) begin
          wb_ack_next = 1'b1;
          pkt_next    = writeback_request_in;
          cnt_next    = '0;
          state_next  = ST_WRITE;
        end else if (miss_request_valid_in) begin
          miss_ack_next = 1'b1;
          pkt_next      = miss_request_in;
          cnt_next      = '0;
          state_next    = ST_READ;
        end
      end
      ST_WRITE: begin
        if (count_done) begin
          mem_we     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_READ: begin
        if (count_done) begin
          resp_pkt_next = pkt;
          resp_pkt_next[DATA_POS_LO +: BLOCK_SIZE_IN_BITS] = mem[idx];
          resp_valid_next = 1'b1;
          state_next      = ST_RESP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (fetched_request_valid_out && fetched_request_ack_in) begin
          resp_valid_next = 1'b0;
          state_next      = ST_IDLE;
        end
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state                     <= ST_IDLE;
      cnt                       <= '0;
      pkt                       <= '0;
      miss_request_ack_out      <= 1'b0;
      writeback_request_ack_out <= 1'b0;
      fetched_request_valid_out <= 1'b0;
      fetched_request_out       <= '0;
    end else begin
      state                     <= state_next;
      cnt                       <= cnt_next;
      pkt                       <= pkt_next;
      miss_request_ack_out      <= miss_ack_next;
      writeback_request_ack_out <= wb_ack_next;
      fetched_request_valid_out <= resp_valid_next;
      fetched_request_out       <= resp_pkt_next;
    end
  end

  // Block array, intentionally not reset
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem[idx] <= pkt[DATA_POS_LO +: BLOCK_SIZE_IN_BITS];
    end
  end

`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  logic resp_hs, stall_cycle;

  assign resp_hs     = (state == ST_RESP) && fetched_request_valid_out && fetched_request_ack_in;
  assign stall_cycle = (state == ST_RESP) && fetched_request_valid_out && !fetched_request_ack_in;

  // Saturating service and stall counters
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      stat_miss_served_out      <= '0;
      stat_writeback_served_out <= '0;
      stat_stall_cycles_out     <= '0;
    end else begin
      if (resp_hs && stat_miss_served_out != 32'hFFFF_FFFF)
        stat_miss_served_out <= stat_miss_served_out + 32'd1;
      if (mem_we && stat_writeback_served_out != 32'hFFFF_FFFF)
        stat_writeback_served_out <= stat_writeback_served_out + 32'd1;
      if (stall_cycle && stat_stall_cycles_out != 32'hFFFF_FFFF)
        stat_stall_cycles_out <= stat_stall_cycles_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Bench for unified_cache_mem_responder: directed scenarios plus random
// miss/writeback traffic against a flat block-array reference model.
`timescale 1ns/1ps

module tb_unified_cache_mem_responder;

  localparam int unsigned PW  = 64;
  localparam int unsigned LAT = 4;
  localparam int unsigned NB  = 16;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [PW-1:0] miss_request_in;
  logic          miss_request_valid_in;
  logic          miss_request_ack_out;
  logic [PW-1:0] writeback_request_in;
  logic          writeback_request_valid_in;
  logic          writeback_request_ack_out;
  logic [PW-1:0] fetched_request_out;
  logic          fetched_request_valid_out;
  logic          fetched_request_ack_in;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  logic [31:0]   stat_miss_served_out;
  logic [31:0]   stat_writeback_served_out;
  logic [31:0]   stat_stall_cycles_out;
  int unsigned   exp_miss, exp_wb, exp_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [NB];

  always #5 clk_in = ~clk_in;

  unified_cache_mem_responder #(
    .PACKET_WIDTH(PW), .ACCESS_LATENCY(LAT), .NUM_BLOCKS(NB)
  ) dut (
    .clk_in                     (clk_in),
    .reset_in                   (reset_in),
    .miss_request_in            (miss_request_in),
    .miss_request_valid_in      (miss_request_valid_in),
    .miss_request_ack_out       (miss_request_ack_out),
    .writeback_request_in       (writeback_request_in),
    .writeback_request_valid_in (writeback_request_valid_in),
    .writeback_request_ack_out  (writeback_request_ack_out),
    .fetched_request_out        (fetched_request_out),
    .fetched_request_valid_out  (fetched_request_valid_out),
    .fetched_request_ack_in     (fetched_request_ack_in)
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    ,
    .stat_miss_served_out       (stat_miss_served_out),
    .stat_writeback_served_out  (stat_writeback_served_out),
    .stat_stall_cycles_out      (stat_stall_cycles_out)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Block index: address divided by the 4-byte block, modulo array depth
  function automatic int blk(input logic [31:0] addr);
    return int'((addr / 4) % NB);
  endfunction

  task automatic wait_ack(input bit is_wb, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (is_wb ? writeback_request_ack_out : miss_request_ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [31:0] data);
    bit ok;
    writeback_request_in       = {data, addr};
    writeback_request_valid_in = 1'b1;
    wait_ack(1'b1, ok);
    writeback_request_valid_in = 1'b0;
    if (ok) begin
      check("wb_only_one_ack", 64'(miss_request_ack_out), 64'd0);
      model_mem[blk(addr)] = data;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
      exp_wb++;
`endif
    end
  endtask

  // Called right after the miss ack was observed
  task automatic finish_miss(input logic [31:0] addr, input int stall, input bit noisy);
    int n;
    bit got;
    logic [63:0] exp_pkt;
    miss_request_valid_in = 1'b0;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fetched_request_ack_in = noisy ? 1'($urandom % 2) : 1'b0;
      tick();
      n++;
      if (n == 1) check("miss_ack_pulse", 64'(miss_request_ack_out), 64'd0);
      if (fetched_request_valid_out) begin
        got = 1'b1;
        break;
      end
    end
    fetched_request_ack_in = 1'b0;
    if (!got) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    exp_pkt = {model_mem[blk(addr)], addr};
    check("miss_latency", 64'(n), 64'(LAT));
    check("resp_pkt", fetched_request_out, exp_pkt);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 64'(fetched_request_valid_out), 64'd1);
      check("stall_pkt", fetched_request_out, exp_pkt);
      check("stall_no_ack", 64'({miss_request_ack_out, writeback_request_ack_out}), 64'd0);
    end
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    exp_stall += stall;
    exp_miss++;
`endif
    fetched_request_ack_in = 1'b1;
    tick();
    fetched_request_ack_in = 1'b0;
    check("resp_drop", 64'(fetched_request_valid_out), 64'd0);
  endtask

  task automatic do_miss(input logic [31:0] addr, input int stall, input bit noisy);
    bit ok;
    miss_request_in       = {32'($urandom), addr};
    miss_request_valid_in = 1'b1;
    wait_ack(1'b0, ok);
    if (ok) finish_miss(addr, stall, noisy);
    else miss_request_valid_in = 1'b0;
  endtask

  initial begin
    bit ok;
    reset_in                   = 1'b0;
    miss_request_in            = '0;
    miss_request_valid_in      = 1'b0;
    writeback_request_in       = '0;
    writeback_request_valid_in = 1'b0;
    fetched_request_ack_in     = 1'b0;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    exp_miss = 0; exp_wb = 0; exp_stall = 0;
`endif
    tick();
    tick();
    check("rst_valid", 64'(fetched_request_valid_out), 64'd0);
    check("rst_pkt", fetched_request_out, 64'd0);
    check("rst_acks", 64'({miss_request_ack_out, writeback_request_ack_out}), 64'd0);
    reset_in = 1'b1;
    tick();

    // Writeback then miss to the same block
    do_wb(32'h8, 32'hDEADBEEF);
    do_miss(32'h8, 0, 1'b0);

    // Reset pulse while a read is counting
    miss_request_in       = {32'h0, 32'h8};
    miss_request_valid_in = 1'b1;
    wait_ack(1'b0, ok);
    miss_request_valid_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b0;
    #1;
    check("midrst_valid", 64'(fetched_request_valid_out), 64'd0);
    check("midrst_acks", 64'({miss_request_ack_out, writeback_request_ack_out}), 64'd0);
    tick();
    reset_in = 1'b1;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    exp_miss = 0; exp_wb = 0; exp_stall = 0;
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dropped_no_resp", 64'(fetched_request_valid_out), 64'd0);
    end
    do_miss(32'h8, 0, 1'b0);

    // Simultaneous writeback and miss to one block
    writeback_request_in       = {32'h11, 32'h4};
    miss_request_in            = {32'hFFFF_FFFF, 32'h4};
    writeback_request_valid_in = 1'b1;
    miss_request_valid_in      = 1'b1;
    wait_ack(1'b1, ok);
    writeback_request_valid_in = 1'b0;
    check("simul_miss_held", 64'(miss_request_ack_out), 64'd0);
    model_mem[blk(32'h4)] = 32'h11;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    exp_wb++;
`endif
    wait_ack(1'b0, ok);
    if (ok) finish_miss(32'h4, 0, 1'b0);
    miss_request_valid_in = 1'b0;

    // Aliasing through ignored high address bits
    do_wb(32'h40, 32'h55);
    do_miss(32'h0, 0, 1'b0);
    check("alias_model", 64'(model_mem[0]), 64'h55);

    // Backpressure
    do_miss(32'h8, 10, 1'b0);

    // Random traffic after filling every block
    for (int b = 0; b < int'(NB); b++) do_wb(32'(b * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 2 == 1) do_wb($urandom, $urandom);
      else do_miss($urandom, int'($urandom % 4), 1'b1);
    end

`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    for (int i = 0; i < int'(LAT) + 2; i++) tick();
    check("stat_miss", 64'(stat_miss_served_out), 64'(exp_miss));
    check("stat_wb", 64'(stat_writeback_served_out), 64'(exp_wb));
    check("stat_stall", 64'(stat_stall_cycles_out), 64'(exp_stall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
